// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter, edge pulses
// and an optional auto-repeat FSM for held buttons.
module debounce_multi #(
   parameter int unsigned     N_CH        = 13,
   parameter int unsigned     CNT_MAX     = 100000,
   parameter int unsigned     SYNC_STAGES = 2,
   parameter logic [N_CH-1:0] REPEAT_MASK = {N_CH{1'b0}},
   parameter int unsigned     REPEAT_DLY  = 50000000,
   parameter int unsigned     REPEAT_PER  = 10000000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] din,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] rep
);

   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [CNT_W-1:0]       cnt_q  [N_CH];
   logic [CNT_W-1:0]       cnt_d  [N_CH];
   logic [1:0]             state_q [N_CH];
   logic [1:0]             state_d [N_CH];
   logic [REP_W-1:0]       rcnt_q [N_CH];
   logic [REP_W-1:0]       rcnt_d [N_CH];

   logic [N_CH-1:0] s;
   logic [N_CH-1:0] level_d;
   logic [N_CH-1:0] rise_d;
   logic [N_CH-1:0] fall_d;
   logic [N_CH-1:0] rep_d;

   // Last synchroniser stage of each channel
   always_comb begin
      s = '0;
      for (int i = 0; i < N_CH; i++) begin
         s[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   // Stability counter: a new level is accepted after CNT_MAX disagreeing samples in a row
   always_comb begin
      level_d = level;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s[i] == level[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] < CNT_W'(CNT_MAX - 1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else begin
            level_d[i] = s[i];
            rise_d[i]  = s[i];
            fall_d[i]  = ~s[i];
            cnt_d[i]   = '0;
         end
      end
   end

   // Auto-repeat next-state; a release always wins over a due repeat pulse
   always_comb begin
      rep_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         rcnt_d[i]  = rcnt_q[i];
         if (!REPEAT_MASK[i]) begin
            state_d[i] = ST_IDLE;
            rcnt_d[i]  = '0;
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  if (rise_d[i]) begin
                     state_d[i] = ST_DELAY;
                     rcnt_d[i]  = REP_W'(1);
                  end
               end
               ST_DELAY: begin
                  if (fall_d[i]) begin
                     state_d[i] = ST_IDLE;
                     rcnt_d[i]  = '0;
                  end else if (rcnt_q[i] == REP_W'(REPEAT_DLY)) begin
                     rep_d[i]   = 1'b1;
                     state_d[i] = ST_REPEAT;
                     rcnt_d[i]  = REP_W'(1);
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + REP_W'(1);
                  end
               end
               ST_REPEAT: begin
                  if (fall_d[i]) begin
                     state_d[i] = ST_IDLE;
                     rcnt_d[i]  = '0;
                  end else if (rcnt_q[i] == REP_W'(REPEAT_PER)) begin
                     rep_d[i]  = 1'b1;
                     rcnt_d[i] = REP_W'(1);
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + REP_W'(1);
                  end
               end
               default: begin
                  state_d[i] = ST_IDLE;
                  rcnt_d[i]  = '0;
               end
            endcase
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            sync_q[i]  <= '0;
            cnt_q[i]   <= '0;
            state_q[i] <= ST_IDLE;
            rcnt_q[i]  <= '0;
         end
         level <= '0;
         rise  <= '0;
         fall  <= '0;
         rep   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
            cnt_q[i]   <= cnt_d[i];
            state_q[i] <= state_d[i];
            rcnt_q[i]  <= rcnt_d[i];
         end
         level <= level_d;
         rise  <= rise_d;
         fall  <= fall_d;
         rep   <= rep_d;
      end
   end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel debouncer and edge detector for the board's push-buttons and slide switches. Each channel synchronises its raw input and accepts a new level only after it has been stable for CNT_MAX clocks. Each channel then emits a clean level plus one-cycle rise and fall pulses. Channels selected by REPEAT_MASK also emit auto-repeat pulses while held, for cursor movement in the game logic.

Parameters:
N_CH, 13, number of independent channels (e.g. 5 buttons + 8 switches).
CNT_MAX, 100000, consecutive stable cycles required to accept a new level; must be >= 1.
SYNC_STAGES, 2, flip-flop synchroniser depth per channel; must be >= 2.
REPEAT_MASK, {N_CH{1'b0}}, per-channel enable for auto-repeat (bit i = channel i).
REPEAT_DLY, 50000000, cycles from the rise pulse to the first repeat pulse; must be >= 1.
REPEAT_PER, 10000000, cycles between subsequent repeat pulses; must be >= 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  N_CH  raw, asynchronous, bouncing inputs.
level  output  N_CH  debounced level per channel.
rise  output  N_CH  one-cycle pulse when level goes 0->1.
fall  output  N_CH  one-cycle pulse when level goes 1->0.
rep  output  N_CH  one-cycle auto-repeat pulse; constant 0 on channels with a clear mask bit.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser stages, counters, level, rise, fall and rep are 0, and every repeat FSM is in IDLE. Reset asserted mid-count discards all progress.
- Channels are fully independent. There is no shared counter.
- Synchroniser: din[i] passes through SYNC_STAGES flops. The last stage is s[i].
- Debounce counter: width is $clog2(CNT_MAX+1), held as an internal localparam.
  - If s[i]==level[i], the counter is cleared to 0.
  - Else, if count < CNT_MAX-1, the counter increments.
  - Else (count == CNT_MAX-1): level[i] <= s[i] and the counter is cleared.
  - Any single sample equal to level[i] restarts the count. Glitches shorter than CNT_MAX cycles are therefore never seen.
- Latency: din held at a new value before edge 1 gives a level change at edge SYNC_STAGES+CNT_MAX.
- rise[i] and fall[i] are registered on the same edge that updates level[i] and last exactly one cycle. They never assert together.
- Repeat FSM (per channel, only if REPEAT_MASK[i]=1), with states IDLE, DELAY, REPEAT and a repeat counter sized for max(REPEAT_DLY, REPEAT_PER).
  - IDLE: on the edge where level[i] becomes 1 (same edge as rise), go to DELAY and set the counter to 1.
  - DELAY: the counter increments each cycle. When it reaches REPEAT_DLY, pulse rep[i], go to REPEAT and set the counter to 1.
  - REPEAT: the counter increments each cycle. When it reaches REPEAT_PER, pulse rep[i] and set the counter to 1.
  - In DELAY or REPEAT, the edge that clears level[i] returns the FSM to IDLE and suppresses any rep pulse on that edge. A fall pulse and a rep pulse never coincide.
  - Result: with rise at cycle t, rep fires at t+REPEAT_DLY, t+REPEAT_DLY+REPEAT_PER, and so on.
- Channels with REPEAT_MASK[i]=0 hold the FSM in IDLE and drive rep[i]=0.
- All outputs are registered. There are no combinational paths from din.
- Simultaneous activity on several channels is handled independently on the same edge.

Test Plan:
All scenarios use N_CH=4, CNT_MAX=4, SYNC_STAGES=2, REPEAT_MASK=4'b0001, REPEAT_DLY=10, REPEAT_PER=3.
1. Reset: rst_n=0 with din=4'hF, released asynchronously between edges -> all outputs 0 during reset and on the first edge after release; level[3:0] rises 6 edges after release.
2. Clean press: din[1] 0->1 before edge 1 and held -> level[1]=1 and rise[1]=1 at edge 6; rise[1]=0 at edge 7; rep[1] stays 0 throughout.
3. Bounce: din[2] toggles 1,0,1,0,1 on consecutive cycles, then stays 1 -> no rise during bouncing; rise[2] exactly 6 edges after the final 0->1 transition; exactly one rise pulse in total.
4. Short glitch: din[3] high for 3 cycles, then low -> level[3], rise[3] and fall[3] remain 0 throughout.
5. Auto-repeat: din[0] held high, rise[0] at cycle t -> rep[0] at t+10, t+13, t+16. Release din[0] -> fall[0] pulses 6 cycles later, no rep on or after that edge, FSM back in IDLE.
6. Reset mid-count: din[1] high for 3 cycles, pulse rst_n low, keep din[1] high -> level[1] rises 6 edges after release, not earlier.
